// File: rtl/pokey_pkg.sv
// Shared constants for the POKEY register slice: register offsets inside the
// 16-byte window, reset values and polynomial-counter tap positions.
// Imported by pokey_lfsr and pokey_regs.
package pokey_pkg;

  // Write-side offsets
  localparam logic [3:0] AUDF1_OFF  = 4'h0;
  localparam logic [3:0] AUDC1_OFF  = 4'h1;
  localparam logic [3:0] AUDF2_OFF  = 4'h2;
  localparam logic [3:0] AUDC2_OFF  = 4'h3;
  localparam logic [3:0] AUDF3_OFF  = 4'h4;
  localparam logic [3:0] AUDC3_OFF  = 4'h5;
  localparam logic [3:0] AUDF4_OFF  = 4'h6;
  localparam logic [3:0] AUDC4_OFF  = 4'h7;
  localparam logic [3:0] AUDCTL_OFF = 4'h8;
  localparam logic [3:0] STIMER_OFF = 4'h9;
  localparam logic [3:0] IRQEN_OFF  = 4'hE;
  localparam logic [3:0] SKCTL_OFF  = 4'hF;

  // Read-side offsets (share addresses with write-only registers)
  localparam logic [3:0] RANDOM_OFF = 4'hA;
  localparam logic [3:0] IRQST_OFF  = 4'hE;
  localparam logic [3:0] SKSTAT_OFF = 4'hF;

  // Reset values
  localparam logic [7:0]  REG_RST   = 8'h00;
  localparam logic [2:0]  IRQST_RST = 3'b111;   // active-low status, all clear
  localparam logic [7:0]  OPEN_BUS  = 8'hFF;    // unmapped reads
  localparam logic [16:0] LFSR_SEED = 17'h1FFFF;

  // Polynomial taps
  localparam int LFSR17_TAP_A = 16;
  localparam int LFSR17_TAP_B = 11;
  localparam int LFSR9_TAP_A  = 8;
  localparam int LFSR9_TAP_B  = 3;

endpackage

// File: rtl/pokey_lfsr.sv
// Purpose: 17/9-bit polynomial counter feeding the RANDOM register.
// Latency: free-running, shifts every clk179; random is a view of the state.
// Backpressure: none. Ports: clk179/init_L, mode9 (AUDCTL[7]), hold
// (SKCTL init), random (8-bit byte presented to the read mux).
module pokey_lfsr
  import pokey_pkg::*;
(
  input  logic       clk179,
  input  logic       init_L,
  input  logic       mode9,
  input  logic       hold,
  output logic [7:0] random
);

  logic [16:0] lfsr;

  always_ff @(posedge clk179 or negedge init_L) begin
    if (!init_L) begin
      lfsr <= LFSR_SEED;
    end else if (hold) begin
      lfsr <= LFSR_SEED;
    end else if (mode9) begin
      // Only the low 9 bits circulate; upper bits freeze so that a mode
      // switch continues from the existing state rather than reseeding.
      lfsr[8:0] <= {lfsr[7:0], lfsr[LFSR9_TAP_A] ^ lfsr[LFSR9_TAP_B]};
    end else begin
      lfsr <= {lfsr[15:0], lfsr[LFSR17_TAP_A] ^ lfsr[LFSR17_TAP_B]};
    end
  end

  assign random = mode9 ? lfsr[8:1] : lfsr[16:9];

endmodule

// File: rtl/pokey_regs.sv
// Purpose: CPU register file for POKEY ($D2xx): AUDF/AUDC/AUDCTL latches,
//   RANDOM, IRQ status/enable and IRQ_L. Build with POKEY_MIRROR_EN to
//   mirror the 16 registers across the whole $D2xx page.
// Latency: writes land on the next edge; dout/rd_hit valid one cycle after
//   the strobe; irq_L follows a status change by one cycle.
// Backpressure: none, every strobed access completes in one cycle.
// Ports: clk179/init_L, bus_valid/addr/rw/din (CPU bus), dout/rd_hit (read
//   return), AUDF1-4/AUDC1-4/AUDCTL (to pokeyaudio), stimer pulse,
//   timer_ev (underflows of timers 1,2,4), irq_L.
module pokey_regs
  import pokey_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hD200,
  parameter logic [7:0]  SKSTAT_VAL = 8'hFF
) (
  input  logic        clk179,
  input  logic        init_L,
  input  logic        bus_valid,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        rd_hit,
  output logic [7:0]  AUDF1,
  output logic [7:0]  AUDF2,
  output logic [7:0]  AUDF3,
  output logic [7:0]  AUDF4,
  output logic [7:0]  AUDC1,
  output logic [7:0]  AUDC2,
  output logic [7:0]  AUDC3,
  output logic [7:0]  AUDC4,
  output logic [7:0]  AUDCTL,
  output logic        stimer,
  input  logic [2:0]  timer_ev,
  output logic        irq_L
);

  logic       hit;
  logic       wr;
  logic       rd;
  logic [3:0] idx;
  logic [2:0] irqen;       // only timer 1/2/4 enables have any effect
  logic [2:0] irqen_nxt;
  logic [2:0] irqst;       // active-low, bit i cleared by timer_ev[i]
  logic [2:0] irqst_nxt;
  logic [1:0] skctl;       // only the init bits are consumed here
  logic [7:0] random;
  logic [7:0] rdata;

`ifdef POKEY_MIRROR_EN
  assign hit = bus_valid & (addr[15:8] == BASE_ADDR[15:8]);
`else
  assign hit = bus_valid & (addr[15:4] == BASE_ADDR[15:4]);
`endif

  assign wr  = hit & ~rw;
  assign rd  = hit & rw;
  assign idx = addr[3:0];

  pokey_lfsr u_lfsr (
    .clk179 (clk179),
    .init_L (init_L),
    .mode9  (AUDCTL[7]),
    .hold   (skctl == 2'b00),
    .random (random)
  );

  // The enable value being written this cycle decides whether a
  // coincident timer event latches, and a cleared enable wins over an event.
  always_comb begin
    irqen_nxt = irqen;
    if (wr && idx == IRQEN_OFF) begin
      irqen_nxt = din[2:0];
    end
    irqst_nxt = irqst;
    for (int i = 0; i < 3; i++) begin
      if (!irqen_nxt[i]) begin
        irqst_nxt[i] = 1'b1;
      end else if (timer_ev[i]) begin
        irqst_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rdata = OPEN_BUS;
    case (idx)
      RANDOM_OFF: rdata = random;
      IRQST_OFF:  rdata = {5'b11111, irqst};
      SKSTAT_OFF: rdata = SKSTAT_VAL;
      default:    rdata = OPEN_BUS;
    endcase
  end

  always_ff @(posedge clk179 or negedge init_L) begin
    if (!init_L) begin
      AUDF1  <= REG_RST;
      AUDF2  <= REG_RST;
      AUDF3  <= REG_RST;
      AUDF4  <= REG_RST;
      AUDC1  <= REG_RST;
      AUDC2  <= REG_RST;
      AUDC3  <= REG_RST;
      AUDC4  <= REG_RST;
      AUDCTL <= REG_RST;
      skctl  <= 2'b00;
      irqen  <= 3'b000;
      irqst  <= IRQST_RST;
      stimer <= 1'b0;
      dout   <= REG_RST;
      rd_hit <= 1'b0;
      irq_L  <= 1'b1;
    end else begin
      if (wr) begin
        case (idx)
          AUDF1_OFF:  AUDF1  <= din;
          AUDC1_OFF:  AUDC1  <= din;
          AUDF2_OFF:  AUDF2  <= din;
          AUDC2_OFF:  AUDC2  <= din;
          AUDF3_OFF:  AUDF3  <= din;
          AUDC3_OFF:  AUDC3  <= din;
          AUDF4_OFF:  AUDF4  <= din;
          AUDC4_OFF:  AUDC4  <= din;
          AUDCTL_OFF: AUDCTL <= din;
          SKCTL_OFF:  skctl  <= din[1:0];
          default:    ;
        endcase
      end
      irqen  <= irqen_nxt;
      irqst  <= irqst_nxt;
      stimer <= wr && (idx == STIMER_OFF);
      rd_hit <= rd;
      if (rd) begin
        dout <= rdata;
      end
      // Built from the registered status, so irq_L trails it by one cycle.
      irq_L <= ~|(~irqst & irqen);
    end
  end

endmodule

// File: tb/tb_pokey_regs.sv
// Directed bench for pokey_regs: register writes, read mux, RANDOM against a
// reference polynomial model, IRQ status/enable, stimer and async reset.
module tb_pokey_regs;

  logic        clk179 = 1'b0;
  logic        init_L;
  logic        bus_valid;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd_hit;
  logic [7:0]  AUDF1, AUDF2, AUDF3, AUDF4;
  logic [7:0]  AUDC1, AUDC2, AUDC3, AUDC4;
  logic [7:0]  AUDCTL;
  logic        stimer;
  logic [2:0]  timer_ev;
  logic        irq_L;

  int ncmp = 0;
  int nbad = 0;

  // Reference model of the polynomial counter and the registers steering it
  logic [16:0] m_lfsr;
  logic [7:0]  m_audctl;
  logic [7:0]  m_skctl;

  logic [7:0]  rd_d;
  logic        rd_h;
  logic [7:0]  rd_exp;
  logic [7:0]  r1;
  logic [7:0]  r2;

  always #5 clk179 = ~clk179;

  pokey_regs dut (
    .clk179    (clk179),
    .init_L    (init_L),
    .bus_valid (bus_valid),
    .addr      (addr),
    .rw        (rw),
    .din       (din),
    .dout      (dout),
    .rd_hit    (rd_hit),
    .AUDF1     (AUDF1),
    .AUDF2     (AUDF2),
    .AUDF3     (AUDF3),
    .AUDF4     (AUDF4),
    .AUDC1     (AUDC1),
    .AUDC2     (AUDC2),
    .AUDC3     (AUDC3),
    .AUDC4     (AUDC4),
    .AUDCTL    (AUDCTL),
    .stimer    (stimer),
    .timer_ev  (timer_ev),
    .irq_L     (irq_L)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_random();
    return m_audctl[7] ? m_lfsr[8:1] : m_lfsr[16:9];
  endfunction

  task automatic m_reset();
    m_lfsr   = 17'h1FFFF;
    m_audctl = 8'h00;
    m_skctl  = 8'h00;
  endtask

  // One clock; the model advances with the register values in force at the edge.
  task automatic tick();
    @(posedge clk179);
    if (init_L) begin
      if (m_skctl[1:0] == 2'b00)
        m_lfsr = 17'h1FFFF;
      else if (m_audctl[7])
        m_lfsr[8:0] = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[3]};
      else
        m_lfsr = {m_lfsr[15:0], m_lfsr[16] ^ m_lfsr[11]};
    end
    #1;
  endtask

  function automatic logic in_window(input logic [15:0] a);
`ifdef POKEY_MIRROR_EN
    return a[15:8] == 8'hD2;
`else
    return a[15:4] == 12'hD20;
`endif
  endfunction

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_valid = 1'b1; rw = 1'b0; addr = a; din = d;
    tick();
    bus_valid = 1'b0; rw = 1'b1;
    if (in_window(a) && a[3:0] == 4'h8) m_audctl = d;
    if (in_window(a) && a[3:0] == 4'hF) m_skctl  = d;
  endtask

  task automatic rd(input logic [15:0] a);
    rd_exp = m_random();
    bus_valid = 1'b1; rw = 1'b1; addr = a;
    tick();
    rd_d = dout; rd_h = rd_hit;
    bus_valid = 1'b0;
  endtask

  initial begin
    init_L = 1'b0; bus_valid = 1'b0; addr = 16'h0000; rw = 1'b1;
    din = 8'h00; timer_ev = 3'b000;
    m_reset();
    #12;
    chk("rst_dout",   {8'h0, dout},   16'h0000);
    chk("rst_rd_hit", {15'h0, rd_hit}, 16'h0000);
    chk("rst_stimer", {15'h0, stimer}, 16'h0000);
    chk("rst_irq_L",  {15'h0, irq_L},  16'h0001);
    chk("rst_audf",   {AUDF1, AUDF4},  16'h0000);
    chk("rst_audc",   {AUDC1, AUDC4},  16'h0000);
    chk("rst_audctl", {8'h0, AUDCTL},  16'h0000);
    @(negedge clk179);
    init_L = 1'b1;
    tick();

    // Basic register writes
    wr(16'hD200, 8'h3C);
    wr(16'hD201, 8'hA8);
    wr(16'hD208, 8'h01);
    chk("audf1",  {8'h0, AUDF1},  16'h003C);
    chk("audc1",  {8'h0, AUDC1},  16'h00A8);
    chk("audctl", {8'h0, AUDCTL}, 16'h0001);
    chk("others", {AUDF2, AUDF3, AUDF4, AUDC2} , 16'h0000);
    chk("others2", {AUDC3, AUDC4}, 16'h0000);
    wr(16'hD300, 8'h77);
    chk("offpage_wr", {8'h0, AUDF1}, 16'h003C);

    // Read mux with counter held by SKCTL = 0
    rd(16'hD20A);
    chk("rand_held", {8'h0, rd_d}, 16'h00FF);
    chk("rand_hit",  {15'h0, rd_h}, 16'h0001);
    tick();
    chk("rd_hit_drop", {15'h0, rd_hit}, 16'h0000);
    chk("dout_hold",   {8'h0, dout},    16'h00FF);
    rd(16'hD200);
    chk("rd_audf_open", {8'h0, rd_d}, 16'h00FF);

    // 17-bit polynomial running
    wr(16'hD20F, 8'h03);
    repeat (20) tick();
    rd(16'hD20A);
    r1 = rd_d;
    chk("rand17_a", {8'h0, r1}, {8'h0, rd_exp});
    repeat (10) tick();
    rd(16'hD20A);
    r2 = rd_d;
    chk("rand17_b", {8'h0, r2}, {8'h0, rd_exp});
    chk("rand_differ", {15'h0, r1 != r2}, 16'h0001);

    // Switch to 9-bit mode without reseeding
    wr(16'hD208, 8'h80);
    repeat (5) tick();
    rd(16'hD20A);
    chk("rand9", {8'h0, rd_d}, {8'h0, rd_exp});

    // IRQ: enabled event, then enable cleared
    wr(16'hD20E, 8'h01);
    timer_ev = 3'b001;
    tick();
    timer_ev = 3'b000;
    chk("irq_L_lag", {15'h0, irq_L}, 16'h0001);
    rd(16'hD20E);
    chk("irqst_fe", {8'h0, rd_d}, 16'h00FE);
    chk("irq_L_low", {15'h0, irq_L}, 16'h0000);
    wr(16'hD20E, 8'h00);
    tick();
    rd(16'hD20E);
    chk("irqst_clr", {8'h0, rd_d}, 16'h00FF);
    chk("irq_L_high", {15'h0, irq_L}, 16'h0001);

    // Event coinciding with an enable write
    timer_ev = 3'b010;
    wr(16'hD20E, 8'h02);
    timer_ev = 3'b000;
    rd(16'hD20E);
    chk("irqst_fd", {8'h0, rd_d}, 16'h00FD);
    chk("irq_L_t2", {15'h0, irq_L}, 16'h0000);
    timer_ev = 3'b010;
    wr(16'hD20E, 8'h00);
    timer_ev = 3'b000;
    rd(16'hD20E);
    chk("irqst_dis", {8'h0, rd_d}, 16'h00FF);
    tick();
    chk("irq_L_t2_off", {15'h0, irq_L}, 16'h0001);
    timer_ev = 3'b100;
    tick();
    timer_ev = 3'b000;
    rd(16'hD20E);
    chk("irqst_ev_noen", {8'h0, rd_d}, 16'h00FF);

    // STIMER pulse, then reset in the middle of a second pulse
    wr(16'hD209, 8'hAA);
    chk("stimer_hi", {15'h0, stimer}, 16'h0001);
    tick();
    chk("stimer_lo", {15'h0, stimer}, 16'h0000);
    wr(16'hD209, 8'h00);
    chk("stimer_hi2", {15'h0, stimer}, 16'h0001);
    #2;
    init_L = 1'b0;
    m_reset();
    #1;
    chk("mid_rst_stimer", {15'h0, stimer}, 16'h0000);
    chk("mid_rst_aud",    {AUDF1, AUDC1},  16'h0000);
    chk("mid_rst_audctl", {8'h0, AUDCTL},  16'h0000);
    chk("mid_rst_dout",   {8'h0, dout},    16'h0000);
    chk("mid_rst_irq_L",  {15'h0, irq_L},  16'h0001);
    @(negedge clk179);
    init_L = 1'b1;
    tick();

    // Address $D218: mirror of AUDCTL only when mirroring is built in
    wr(16'hD218, 8'h55);
    rd(16'hD218);
`ifdef POKEY_MIRROR_EN
    chk("mirror_wr",   {8'h0, AUDCTL}, 16'h0055);
    chk("mirror_rhit", {15'h0, rd_h},  16'h0001);
    chk("mirror_dout", {8'h0, rd_d},   16'h00FF);
`else
    chk("mirror_wr",   {8'h0, AUDCTL}, 16'h0000);
    chk("mirror_rhit", {15'h0, rd_h},  16'h0000);
    chk("mirror_dout", {8'h0, rd_d},   16'h0000);
`endif
    rd(16'hD20E);
    chk("post_rst_irqst", {8'h0, rd_d}, 16'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
